wave_nco_generator: RTL and testbench

- Parametrised phase-accumulator (NCO) waveform source. It is the successor to the fixed 6-bit lookup-table sawtooth source.
- Generates up-sawtooth, down-sawtooth, triangle or square at a runtime-programmable frequency word.
- Mode changes are glitch-free: they take effect only at a period boundary.
- Adds enable, phase sync, a wrap strobe and an output-valid flag. Feeds the signal-processing and VGA display paths.

---
 rtl/wave_nco_generator_if.sv | 30 +++
 rtl/wave_nco_generator.sv | 97 +++++++++
 tb/tb_wave_nco_generator.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/wave_nco_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : wave_nco_generator_if
// Description : Control and sample bus of the NCO waveform source. The master
//               side drives enable/sync/frequency/mode and receives samples.
// Revision    : 1.0 - initial release
// ============================================================================
interface wave_nco_generator_if #(
  parameter int OUT_W = 6,
  parameter int FO_W  = 9
);
  logic             en;
  logic             sync;
  logic [FO_W-1:0]  fo;
  logic [1:0]       mode;
  logic [OUT_W-1:0] out_wave;
  logic             out_valid;
  logic             wrap;

  modport master (
    output en, sync, fo, mode,
    input  out_wave, out_valid, wrap
  );

  modport slave (
    input  en, sync, fo, mode,
    output out_wave, out_valid, wrap
  );
endinterface
`default_nettype wire

// File: rtl/wave_nco_generator.sv
`default_nettype none
// ============================================================================
// Module      : wave_nco_generator
// Description : Phase-accumulator waveform source producing saw-up, saw-down,
//               triangle or square samples. Requested mode is adopted only on
//               an accumulator wrap or a sync, so waveforms never glitch
//               mid-period.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_nco_generator #(
  parameter int OUT_W = 6,
  parameter int ACC_W = 16,
  parameter int FO_W  = 9
) (
  input  wire logic             clk,
  input  wire logic             reset,
  wave_nco_generator_if.slave   bus
);

  localparam logic [1:0] MODE_SAW_UP   = 2'b00;
  localparam logic [1:0] MODE_SAW_DOWN = 2'b01;
  localparam logic [1:0] MODE_TRIANGLE = 2'b10;
  localparam logic [1:0] MODE_SQUARE   = 2'b11;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [1:0]       mode_act_q, mode_act_d;
  logic [OUT_W-1:0] out_wave_q, out_wave_d;
  logic             out_valid_q, out_valid_d;
  logic             wrap_q, wrap_d;

  logic [ACC_W:0]   sum;
  logic [OUT_W-1:0] p_slice;
  logic [OUT_W-1:0] t_slice;
  logic [OUT_W-1:0] sample;

  // Waveform shaping from the current (pre-increment) phase and active mode
  always_comb begin
    sum     = {1'b0, acc_q} + {{(ACC_W + 1 - FO_W){1'b0}}, bus.fo};
    p_slice = acc_q[ACC_W-1 -: OUT_W];
    // Triangle uses one bit more resolution so each half-period spans full scale
    t_slice = acc_q[ACC_W-2 -: OUT_W];
    sample  = '0;
    case (mode_act_q)
      MODE_SAW_UP:   sample = p_slice;
      MODE_SAW_DOWN: sample = ~p_slice;
      MODE_TRIANGLE: sample = acc_q[ACC_W-1] ? ~t_slice : t_slice;
      MODE_SQUARE:   sample = acc_q[ACC_W-1] ? '0 : {OUT_W{1'b1}};
      default:       sample = '0;
    endcase
  end

  // Next-state selection: sync restarts the phase, en advances it, else hold
  always_comb begin
    acc_d       = acc_q;
    mode_act_d  = mode_act_q;
    out_wave_d  = out_wave_q;
    out_valid_d = 1'b0;
    wrap_d      = 1'b0;
    if (bus.sync) begin
      acc_d      = '0;
      mode_act_d = bus.mode;
      out_wave_d = '0;
    end else if (bus.en) begin
      out_wave_d  = sample;
      acc_d       = sum[ACC_W-1:0];
      wrap_d      = sum[ACC_W];
      out_valid_d = 1'b1;
      // New mode is taken only at a period boundary to keep the output glitch-free
      if (sum[ACC_W]) begin
        mode_act_d = bus.mode;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      mode_act_q  <= MODE_SAW_UP;
      out_wave_q  <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      mode_act_q  <= mode_act_d;
      out_wave_q  <= out_wave_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
    end
  end

  assign bus.out_wave  = out_wave_q;
  assign bus.out_valid = out_valid_q;
  assign bus.wrap      = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_wave_nco_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_wave_nco_generator
// Description : Directed, scoreboard-checked bench for wave_nco_generator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_nco_generator;

  localparam int OUT_W = 6;
  localparam int ACC_W = 16;
  localparam int FO_W  = 9;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  wave_nco_generator_if #(.OUT_W(OUT_W), .FO_W(FO_W)) bus ();

  wave_nco_generator #(.OUT_W(OUT_W), .ACC_W(ACC_W), .FO_W(FO_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [5:0] wave;
    logic       valid;
    logic       wrap;
  } exp_t;

  exp_t  sb[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    wraps       = 0;
  string phase       = "init";

  int m_acc  = 0;
  int m_mode = 0;
  int m_wave = 0;

  // Expected sample computed arithmetically from the phase value
  function automatic int ref_f(input int a, input int m);
    int msb;
    int p;
    int t;
    msb = (a / 32768) % 2;
    p   = (a / 1024) % 64;
    t   = (a / 512) % 64;
    case (m)
      0:       return p;
      1:       return 63 - p;
      2:       return (msb == 1) ? 63 - t : t;
      default: return (msb == 1) ? 0 : 63;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, predict with the model, compare after the edge
  task automatic step(input logic r, input logic s, input logic e, input int f, input int m);
    exp_t x;
    int   sum;
    @(negedge clk);
    reset    = r;
    bus.sync = s;
    bus.en   = e;
    bus.fo   = f[8:0];
    bus.mode = m[1:0];
    x = '0;
    if (r) begin
      m_acc = 0; m_mode = 0; m_wave = 0;
    end else if (s) begin
      m_acc = 0; m_mode = m; m_wave = 0;
    end else if (e) begin
      m_wave  = ref_f(m_acc, m_mode);
      sum     = m_acc + f;
      x.valid = 1'b1;
      if (sum >= 65536) begin
        x.wrap = 1'b1;
        m_mode = m;
      end
      m_acc = sum % 65536;
    end
    x.wave = m_wave[5:0];
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (bus.wrap === 1'b1) wraps++;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check("out_wave",  bus.out_wave,  x.wave);
      check("out_valid", bus.out_valid, x.valid);
      check("wrap",      bus.wrap,      x.wrap);
    end
  endtask

  logic [5:0] held;

  initial begin
    reset    = 1'b1;
    bus.sync = 1'b0;
    bus.en   = 1'b0;
    bus.fo   = '0;
    bus.mode = 2'b00;

    phase = "reset";
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 256, 0);
    check("rst_wave", bus.out_wave, 0);
    check("rst_valid", bus.out_valid, 0);

    // Saw-up ramp, 4 samples per code, one wrap per 256 cycles
    phase = "saw_up";
    wraps = 0;
    for (int k = 1; k <= 260; k++) begin
      step(0, 0, 1, 256, 0);
      if (k == 100) check("k100", bus.out_wave, 24);
      if (k == 256) check("wrap_edge", bus.wrap, 1);
      if (k == 256) check("top", bus.out_wave, 63);
      if (k == 257) check("restart", bus.out_wave, 0);
    end
    check("wrap_count", wraps, 1);

    // Triangle from a sync
    phase = "triangle";
    step(0, 1, 0, 0, 2);
    for (int k = 1; k <= 260; k++) begin
      step(0, 0, 1, 256, 2);
      if (k == 125) check("k125", bus.out_wave, 62);
      if (k == 129) check("peak", bus.out_wave, 63);
      if (k == 133) check("k133", bus.out_wave, 61);
    end

    // Mode change to square mid-ramp applies only after the wrap
    phase = "mode_switch";
    step(0, 1, 0, 0, 0);
    for (int k = 1; k <= 512; k++) begin
      step(0, 0, 1, 256, (k > 81) ? 3 : 0);
      if (k == 200) check("still_saw", bus.out_wave, 49);
      if (k == 255) check("ramp_top", bus.out_wave, 63);
      if (k == 257) check("sq_first", bus.out_wave, 63);
      if (k == 384) check("sq_hi_end", bus.out_wave, 63);
      if (k == 385) check("sq_low", bus.out_wave, 0);
    end

    // Hold freezes the output; sync with en restarts from zero
    phase = "hold_sync";
    step(0, 1, 0, 0, 0);
    for (int k = 1; k <= 50; k++) step(0, 0, 1, 256, 0);
    held = bus.out_wave;
    check("pre_hold", held, 12);
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 0, 256, 0);
      check("frozen", bus.out_wave, held);
    end
    step(0, 1, 1, 256, 0);
    check("sync_wave", bus.out_wave, 0);
    check("sync_valid", bus.out_valid, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 1, 256, 0);
      if (k == 5) check("ramp_again", bus.out_wave, 1);
    end

    // Zero increment: constant output, no wrap, no mode adoption
    phase = "zero_fo";
    wraps = 0;
    step(0, 0, 1, 0, 0);
    held = bus.out_wave;
    for (int k = 1; k <= 500; k++) begin
      step(0, 0, 1, 0, (k > 250) ? 1 : 0);
    end
    check("const", bus.out_wave, held);
    check("no_wrap", wraps, 0);
    step(0, 1, 1, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 1, 0, 1);
      check("down_63", bus.out_wave, 63);
    end

    // Reset mid-period at acc=0x8000 in square mode
    phase = "mid_reset";
    step(0, 1, 0, 0, 3);
    for (int k = 1; k <= 128; k++) step(0, 0, 1, 256, 3);
    step(1, 0, 1, 256, 2);
    check("after_rst", bus.out_wave, 0);
    for (int k = 1; k <= 300; k++) begin
      step(0, 0, 1, 256, 2);
      if (k == 1)   check("first", bus.out_wave, 0);
      if (k == 100) check("saw_after_rst", bus.out_wave, 24);
      if (k == 259) check("tri_after_wrap", bus.out_wave, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
